fetch_sequencer: RTL
====================

# fetch_sequencer

Parametrised instruction-cycle sequencer for the TB4004 core: generates the per-instruction phase counter and `sync`, owns the program counter, and contains the subroutine return stack. It replaces the separate phase generator, program counter and stack instances in `cpuTop`, and adds commit-time jump, call and return handling with configurable stack depth and overflow/underflow reporting.

## Interface
- `ADDR_W`, 12: program counter and stack entry width.
- `DEPTH`, 3: return-stack levels; must be ≥ 1.
- `PHASES`, 8: clocks per instruction cycle; must be ≥ 2. `CW = $clog2(PHASES)`, `LW = $clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstN`  in  1  asynchronous active-low reset.
- `hold`  in  1  freezes the sequencer; present only with `FETCH_SEQ_HOLD_EN`.
- `pcLoad`  in  1  jump request: PC ← `pcNew`.
- `pcNew`  in  ADDR_W  jump or call target.
- `push`  in  1  call request: stack ← PC+1, PC ← `pcNew`.
- `pop`  in  1  return request: PC ← stack top.
- `cycle`  out  CW  current phase, 0..PHASES-1.
- `sync`  out  1  high while `cycle == PHASES-1`.
- `pcAddr`  out  ADDR_W  current program counter.
- `stackLevel`  out  LW  occupied entries, 0..DEPTH.
- `stackOverflow`  out  1  sticky flag: a push occurred while the stack was full.
- `stackUnderflow`  out  1  sticky flag: a pop occurred while the stack was empty.

## Operation
- **Phase counter.** Counts 0 → PHASES-1, then wraps to 0. `sync` is decoded from the counter register and contains no other logic.
- **Commit edge.** This is the rising edge on which `cycle == PHASES-1`. `pcLoad`, `push` and `pop` are sampled only on the commit edge and ignored on every other edge.
- **PC and stack actions at commit (priority order):**
  - `push & pop`: PC ← `pcNew`; top entry is overwritten with PC+1; level is unchanged; no flags change. If level is 0, this acts as a plain push.
  - `push`: entry at the write pointer ← PC+1; pointer advances; PC ← `pcNew`.
  - `pop`: pointer retreats; PC ← that entry.
  - `pcLoad`: PC ← `pcNew`.
  - No request: PC ← PC+1.
  - `pcLoad` asserted together with `push` or `pop` is ignored.
- **Arithmetic.** All PC+1 arithmetic is modulo 2^ADDR_W; `{ADDR_W{1}}` increments to 0.
- **Stack storage.** The stack is a circular buffer of DEPTH entries with a wrapping pointer.
- **Push when full** (level == DEPTH): the oldest entry is overwritten, level stays DEPTH, and `stackOverflow` is set.
- **Pop when empty** (level == 0): the pointer still retreats and PC loads the stale entry there (0 if never written). Level stays 0 and `stackUnderflow` is set.
- **Sticky flags** clear only on reset.

## Timing
- **Reset.** Asynchronous reset forces the following; the sequencer restarts at phase 0 on the first edge after `rstN` rises:
  - `cycle` = 0, `sync` = 0 (1 if PHASES = 1 is ever allowed; it is not).
  - `pcAddr` = 0, all stack entries = 0, `stackLevel` = 0.
  - `stackOverflow` = `stackUnderflow` = 0.
- **Reset mid-cycle.** Any in-progress instruction cycle is discarded; no partial commit occurs.
- **Latency.** A commit-edge request is visible on `pcAddr`/`stackLevel`/flags in phase 0 of the next instruction cycle, one clock after the request is sampled.
- **Stability.** `pcAddr` is stable for all PHASES clocks of an instruction cycle.
- **Request timing.** Requests need only be valid during phase PHASES-1; the source is the decoder, driven in the X phases.

## Configuration
- **`FETCH_SEQ_HOLD_EN` defined:** the `hold` port exists.
  - While `hold` = 1 on an edge, the counter, PC, stack and flags do not change.
  - A commit edge with `hold` = 1 does not commit; the requests must remain asserted until a non-held commit edge.
  - `sync` stays at its decoded value.
- **`FETCH_SEQ_HOLD_EN` undefined:** the `hold` port is absent and behaviour is identical to `hold` = 0.

## Test plan
- **Free run.** Release reset and run 24 clocks, defaults. Required: `cycle` reads 0..7 three times; `sync` is high only at `cycle` 7; `pcAddr` = 0x000 → 0x001 → 0x002, each change seen at `cycle` 0.
- **Jump.** `pcLoad` with `pcNew` = 0x3A5 held during `cycle` 3 only: ignored, PC increments normally. The same request held during `cycle` 7: `pcAddr` = 0x3A5 next clock. Separately, from PC = 0xFFF with no request: `pcAddr` → 0x000.
- **Call/return.** At PC = 0x010, `push` with `pcNew` = 0x200: `pcAddr` = 0x200, `stackLevel` = 1. A later `pop`: `pcAddr` = 0x011, `stackLevel` = 0, both flags 0.
- **Overflow/underflow (DEPTH = 3).** Pushes from PCs 0x100, 0x200, 0x300, 0x400: `stackOverflow` = 1, level = 3. Three pops return 0x401, 0x301, 0x201. A fourth pop sets `stackUnderflow` = 1 with level 0.
- **Simultaneous and reset.** `push & pop` with level 1 at PC 0x050, `pcNew` = 0x080: `pcAddr` = 0x080, level 1, a subsequent pop returns 0x051. Reset asserted at `cycle` 4: all outputs read 0 immediately.
- **Hold (`FETCH_SEQ_HOLD_EN`).** Assert `hold` for 5 clocks at `cycle` 7 with `pcLoad` = 1: `cycle` stays 7 and `pcAddr` is unchanged. Release `hold`: the load commits and `cycle` → 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: phase counter, sync, program counter and circular
// return stack for the TB4004 core; requests are acted on only at the commit edge.
//
// Ports:
//   clk, rstN (async active-low), hold (only with FETCH_SEQ_HOLD_EN),
//   pcLoad/pcNew (jump), push (call), pop (return),
//   cycle (phase), sync (last phase), pcAddr (PC), stackLevel (occupied entries),
//   stackOverflow/stackUnderflow (sticky until reset).
//
// Build option: define FETCH_SEQ_HOLD_EN to add the hold port.
module fetch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 3,
  parameter int PHASES = 8,
  localparam int CW = $clog2(PHASES),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstN,
`ifdef FETCH_SEQ_HOLD_EN
  input  logic              hold,
`endif
  input  logic              pcLoad,
  input  logic [ADDR_W-1:0] pcNew,
  input  logic              push,
  input  logic              pop,
  output logic [CW-1:0]     cycle,
  output logic              sync,
  output logic [ADDR_W-1:0] pcAddr,
  output logic [LW-1:0]     stackLevel,
  output logic              stackOverflow,
  output logic              stackUnderflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] stk [DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     wp_inc;
  logic [PW-1:0]     wp_dec;
  logic [ADDR_W-1:0] pc_inc;
  logic              last;
  logic              run;
  logic              full;
  logic              empty;

`ifdef FETCH_SEQ_HOLD_EN
  assign run = !hold;
`else
  assign run = 1'b1;
`endif

  assign last   = (cycle == CW'(PHASES - 1));
  assign sync   = last;
  assign pc_inc = pcAddr + 1'b1;
  assign full   = (stackLevel == LW'(DEPTH));
  assign empty  = (stackLevel == '0);

  // Pointer wraps at DEPTH, which need not be a power of two.
  assign wp_inc = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
  assign wp_dec = (wp == '0) ? PW'(DEPTH - 1) : wp - 1'b1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycle          <= '0;
      pcAddr         <= '0;
      wp             <= '0;
      stackLevel     <= '0;
      stackOverflow  <= 1'b0;
      stackUnderflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk[i] <= '0;
      end
    end else if (run) begin
      cycle <= last ? '0 : cycle + 1'b1;
      if (last) begin
        if (push && pop && !empty) begin
          // Tail call: replace the top return address in place.
          stk[wp_dec] <= pc_inc;
          pcAddr      <= pcNew;
        end else if (push) begin
          // When full, wp already points at the oldest entry.
          stk[wp] <= pc_inc;
          wp      <= wp_inc;
          pcAddr  <= pcNew;
          if (full) begin
            stackOverflow <= 1'b1;
          end else begin
            stackLevel <= stackLevel + 1'b1;
          end
        end else if (pop) begin
          // Empty pop still retreats and returns the stale entry.
          wp     <= wp_dec;
          pcAddr <= stk[wp_dec];
          if (empty) begin
            stackUnderflow <= 1'b1;
          end else begin
            stackLevel <= stackLevel - 1'b1;
          end
        end else if (pcLoad) begin
          pcAddr <= pcNew;
        end else begin
          pcAddr <= pc_inc;
        end
      end
    end
  end

endmodule
